i2s_transmitter: RTL and testbench

- I2S serializer and bus master for the EQ output path: accepts processed left/right sample words over a valid/ready handshake and drives sd and ws for the DAC.
- Sits directly downstream of the equaliser and is the transmit counterpart of the I2S receiver; frame format is identical so tx sd/ws loops back into the receiver bit-exact.
- Single clock domain: sck. All state updates on the falling edge of sck, so the receiver and DAC sample stable sd/ws on the rising edge.

---
 rtl/i2s_transmitter.sv | 143 ++++++++++++++
 tb/tb_i2s_transmitter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_transmitter.sv
// I2S serializer / bus master for the EQ output path.
// Takes one left/right sample pair per frame over a valid/ready handshake and
// drives ws/sd MSB first with the standard one-bit I2S delay. All state moves
// on the falling edge of sck so downstream devices sample stable ws/sd on the
// rising edge.
//
// Handshake: data_L/data_R are valid while load is high; ready is high while
// the holding register is empty. A pair is taken on the falling edge where
// load & ready. load while ready is low is ignored and the held pair is never
// overwritten. The held pair moves into the serializer at the next left-slot
// start, which empties the holding register; a load on that same edge is
// ignored and must be repeated on a later edge.
module i2s_transmitter #(
    parameter int SR_WIDTH   = 32,
    parameter int SLOT_WIDTH = 32
) (
    input  logic                sck,
    input  logic                reset_n,
    input  logic [SR_WIDTH-1:0] data_L,
    input  logic [SR_WIDTH-1:0] data_R,
    input  logic                load,
    output logic                ready,
    output logic                ws,
    output logic                sd,
    output logic                frame_start,
    output logic                underrun
);

    localparam int CNT_W = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_WIDTH - 1);

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    chan_e               chan_q, chan_d;
    logic [SR_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [SR_WIDTH-1:0] hold_r_q, hold_r_d;
    logic                hold_valid_q, hold_valid_d;
    logic [SR_WIDTH-1:0] rlatch_q, rlatch_d;
    logic [SR_WIDTH-1:0] shift_q, shift_d;
    logic                ws_q, ws_d;
    logic                sd_q, sd_d;
    logic                frame_start_q, frame_start_d;
    logic                underrun_q, underrun_d;

    logic                left_start;
    logic                right_start;
    logic [31:0]         cnt_ext;

    // Slot counter, channel, holding register and serializer next state.
    always_comb begin
        cnt_d         = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        chan_d        = chan_q;
        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
        hold_valid_d  = hold_valid_q;
        rlatch_d      = rlatch_q;
        shift_d       = shift_q << 1;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        sd_d          = 1'b0;

        if (cnt_q == CNT_MAX) begin
            chan_d = (chan_q == CH_LEFT) ? CH_RIGHT : CH_LEFT;
        end

        left_start  = (cnt_d == '0) && (chan_d == CH_LEFT);
        right_start = (cnt_d == '0) && (chan_d == CH_RIGHT);
        cnt_ext     = 32'(cnt_d);

        // ws flips during the last bit of a slot, one sck ahead of the data.
        ws_d = (cnt_d == CNT_MAX) ? (chan_d == CH_LEFT) : (chan_d == CH_RIGHT);

        if (left_start) begin
            frame_start_d = 1'b1;
            if (hold_valid_q) begin
                shift_d      = hold_l_q;
                rlatch_d     = hold_r_q;
                hold_valid_d = 1'b0;
            end else begin
                shift_d    = '0;
                rlatch_d   = '0;
                underrun_d = 1'b1;
            end
        end else if (right_start) begin
            shift_d = rlatch_q;
        end

        // Holding register is only written while empty, so a pending pair
        // is never overwritten and consumption always wins the same edge.
        if (load && !hold_valid_q) begin
            hold_l_d     = data_L;
            hold_r_d     = data_R;
            hold_valid_d = 1'b1;
        end

        // Slot bits past the sample width are padded with zeros.
        if (cnt_ext >= 32'(SR_WIDTH)) begin
            sd_d = 1'b0;
        end else begin
            sd_d = shift_d[SR_WIDTH-1];
        end
    end

    // State register, updated on the falling edge of sck.
    always_ff @(negedge sck or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q         <= CNT_MAX;
            chan_q        <= CH_RIGHT;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            hold_valid_q  <= 1'b0;
            rlatch_q      <= '0;
            shift_q       <= '0;
            ws_q          <= 1'b0;
            sd_q          <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            chan_q        <= chan_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            hold_valid_q  <= hold_valid_d;
            rlatch_q      <= rlatch_d;
            shift_q       <= shift_d;
            ws_q          <= ws_d;
            sd_q          <= sd_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign ready       = ~hold_valid_q;
    assign ws          = ws_q;
    assign sd          = sd_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: a 32/32 instance (A) and a 24-in-32 padded
// instance (B). Inputs change 1 time unit after the rising sck edge; outputs
// are sampled on the rising edge, half a period away from the falling edge
// the design updates on. Each frame seen on the wire is deserialized and
// compared with the next entry of that instance's expected queue.
module tb_i2s_transmitter;

  logic        sck;
  logic        rst_a_n, load_a, ready_a, ws_a, sd_a, fs_a, ur_a;
  logic [31:0] dl_a, dr_a;
  logic        rst_b_n, load_b, ready_b, ws_b, sd_b, fs_b, ur_b;
  logic [23:0] dl_b, dr_b;

  // {underrun, left slot bits, right slot bits}
  logic [64:0] exp_a_q[$];
  logic [64:0] exp_b_q[$];

  int checks = 0;
  int failures = 0;

  // ws over one frame, first sampled bit at [63]: high for bits 31..62.
  localparam logic [63:0] WS_PATTERN = 64'h0000_0001_FFFF_FFFE;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } vec_t;
  vec_t tbl[5];

  i2s_transmitter #(.SR_WIDTH(32), .SLOT_WIDTH(32)) dut_a (
    .sck(sck), .reset_n(rst_a_n), .data_L(dl_a), .data_R(dr_a), .load(load_a),
    .ready(ready_a), .ws(ws_a), .sd(sd_a), .frame_start(fs_a), .underrun(ur_a)
  );

  i2s_transmitter #(.SR_WIDTH(24), .SLOT_WIDTH(32)) dut_b (
    .sck(sck), .reset_n(rst_b_n), .data_L(dl_b), .data_R(dr_b), .load(load_b),
    .ready(ready_b), .ws(ws_b), .sd(sd_b), .frame_start(fs_b), .underrun(ur_b)
  );

  // clock / watchdog
  initial sck = 1'b0;
  always #5 sck = ~sck;

  initial begin
    #500000;
    $display("FAIL watchdog got=still_running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic string tag(input bit b);
    return b ? "B" : "A";
  endfunction

  task automatic push_exp(input bit b, input logic [64:0] e);
    if (b) exp_b_q.push_back(e);
    else exp_a_q.push_back(e);
  endtask

  task automatic check_frame(input bit b, input logic [31:0] gl, input logic [31:0] gr,
                             input logic [63:0] gws, input logic [1:0] gur);
    logic [64:0] e;
    if ((b && exp_b_q.size() == 0) || (!b && exp_a_q.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL %s_sb_empty got=frame exp=no_frame", tag(b));
      return;
    end
    if (b) e = exp_b_q.pop_front();
    else e = exp_a_q.pop_front();
    chk({tag(b), "_left_slot"}, 64'(gl), 64'(e[63:32]));
    chk({tag(b), "_right_slot"}, 64'(gr), 64'(e[31:0]));
    chk({tag(b), "_ws_pattern"}, gws, WS_PATTERN);
    chk({tag(b), "_underrun"}, 64'(gur), 64'({e[64], 1'b0}));
  endtask

  // frame monitors: underrun captured at the frame_start bit, any later
  // underrun pulse inside the frame is flagged as stray
  logic [31:0] cap_l_a, cap_r_a, cap_l_b, cap_r_b;
  logic [63:0] cap_ws_a, cap_ws_b;
  int          idx_a, idx_b;
  bit          coll_a, coll_b, urs_a, urs_b, stray_a, stray_b;

  always @(posedge sck) begin
    if (!rst_a_n) begin
      coll_a = 1'b0;
    end else begin
      if (fs_a) begin
        idx_a = 0; coll_a = 1'b1; urs_a = ur_a; stray_a = 1'b0;
      end else if (coll_a && ur_a) begin
        stray_a = 1'b1;
      end
      if (coll_a) begin
        if (idx_a < 32) cap_l_a = {cap_l_a[30:0], sd_a};
        else cap_r_a = {cap_r_a[30:0], sd_a};
        cap_ws_a = {cap_ws_a[62:0], ws_a};
        idx_a++;
        if (idx_a == 64) begin
          coll_a = 1'b0;
          check_frame(1'b0, cap_l_a, cap_r_a, cap_ws_a, {urs_a, stray_a});
        end
      end
    end
  end

  always @(posedge sck) begin
    if (!rst_b_n) begin
      coll_b = 1'b0;
    end else begin
      if (fs_b) begin
        idx_b = 0; coll_b = 1'b1; urs_b = ur_b; stray_b = 1'b0;
      end else if (coll_b && ur_b) begin
        stray_b = 1'b1;
      end
      if (coll_b) begin
        if (idx_b < 32) cap_l_b = {cap_l_b[30:0], sd_b};
        else cap_r_b = {cap_r_b[30:0], sd_b};
        cap_ws_b = {cap_ws_b[62:0], ws_b};
        idx_b++;
        if (idx_b == 64) begin
          coll_b = 1'b0;
          check_frame(1'b1, cap_l_b, cap_r_b, cap_ws_b, {urs_b, stray_b});
        end
      end
    end
  end

  // driver tasks
  task automatic drive(input bit b, input logic ld, input logic [31:0] l, input logic [31:0] r);
    if (b) begin
      load_b = ld; dl_b = l[23:0]; dr_b = r[23:0];
    end else begin
      load_a = ld; dl_a = l; dr_a = r;
    end
  endtask

  function automatic logic get_ready(input bit b);
    return b ? ready_b : ready_a;
  endfunction

  // Returns on the rising edge where frame_start is seen; n = edges waited.
  task automatic sync_frame(input bit b, output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge sck);
      if (b ? fs_b : fs_a) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_frame_start_wait got=none exp=within_200_cycles", tag(b));
    end
  endtask

  // Called at a frame start; loads one pair d cycles in, which must play next frame.
  task automatic load_word(input bit b, input int d, input logic [31:0] l, input logic [31:0] r,
                           input logic [64:0] e);
    chk({tag(b), "_ready_at_frame_start"}, 64'(get_ready(b)), 64'd1);
    repeat (d) @(posedge sck);
    #1 drive(b, 1'b1, l, r);
    push_exp(b, e);
    @(posedge sck);
    chk({tag(b), "_ready_after_load"}, 64'(get_ready(b)), 64'd0);
    #1 drive(b, 1'b0, l, r);
  endtask

  // Called at a frame start; no load, so the next frame must underrun.
  task automatic idle_frame(input bit b);
    chk({tag(b), "_ready_at_frame_start"}, 64'(get_ready(b)), 64'd1);
    #1 drive(b, 1'b0, 32'd0, 32'd0);
    push_exp(b, {1'b1, 64'd0});
  endtask

  // Called at a frame start; load stays high with new data every cycle. Only
  // the pair present on the first edge of the frame can be taken.
  task automatic bp_frame(input bit b);
    logic [31:0] l, r;
    chk({tag(b), "_ready_at_frame_start"}, 64'(get_ready(b)), 64'd1);
    for (int i = 0; i < 64; i++) begin
      if (i == 1) chk({tag(b), "_ready_backpressure"}, 64'(get_ready(b)), 64'd0);
      l = $urandom();
      r = $urandom();
      #1 drive(b, 1'b1, l, r);
      if (i == 0) push_exp(b, {1'b0, l, r});
      if (i < 63) @(posedge sck);
    end
  endtask

  task automatic drain(input bit b);
    for (int i = 0; i < 200; i++) begin
      @(posedge sck);
      #1;
      if ((b && exp_b_q.size() == 0) || (!b && exp_a_q.size() == 0)) break;
    end
    chk({tag(b), "_queue_drained"}, 64'(b ? exp_b_q.size() : exp_a_q.size()), 64'd0);
  endtask

  // main sequence
  initial begin
    int n;
    logic [31:0] l, r;

    tbl[0] = '{32'h00FF_FFFF, 32'h0000_0001, 32'hFFFF_FF00, 32'h0000_0100};
    tbl[1] = '{32'h0080_0000, 32'h007F_FFFF, 32'h8000_0000, 32'h7FFF_FF00};
    tbl[2] = '{32'h00A5_A5A5, 32'h005A_5A5A, 32'hA5A5_A500, 32'h5A5A_5A00};
    tbl[3] = '{32'h0000_0000, 32'h00FF_FFFF, 32'h0000_0000, 32'hFFFF_FF00};
    tbl[4] = '{32'h00C0_0003, 32'h0040_0002, 32'hC000_0300, 32'h4000_0200};

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge sck);
    #1;
    chk("A_reset_ws", 64'(ws_a), 64'd0);
    chk("A_reset_sd", 64'(sd_a), 64'd0);
    chk("A_reset_ready", 64'(ready_a), 64'd1);
    chk("A_reset_frame_start", 64'(fs_a), 64'd0);
    chk("A_reset_underrun", 64'(ur_a), 64'd0);

    // release: the very first edge opens a left slot with nothing held
    rst_a_n = 1'b1;
    push_exp(1'b0, {1'b1, 64'd0});
    sync_frame(1'b0, n);
    chk("A_first_frame_start_edges", 64'(n), 64'd1);

    // directed single frame, then an idle frame
    load_word(1'b0, 3, 32'h8000_0001, 32'h1234_5678, {1'b0, 32'h8000_0001, 32'h1234_5678});
    sync_frame(1'b0, n);
    idle_frame(1'b0);
    sync_frame(1'b0, n);

    // latest possible load in a frame still plays in the next one
    load_word(1'b0, 62, 32'hDEAD_BEEF, 32'h0F1E_2D3C, {1'b0, 32'hDEAD_BEEF, 32'h0F1E_2D3C});
    sync_frame(1'b0, n);

    for (int k = 0; k < 4; k++) begin
      l = $urandom();
      r = $urandom();
      load_word(1'b0, int'($urandom_range(0, 62)), l, r, {1'b0, l, r});
      sync_frame(1'b0, n);
    end

    for (int k = 0; k < 3; k++) begin
      bp_frame(1'b0);
      sync_frame(1'b0, n);
    end
    idle_frame(1'b0);
    sync_frame(1'b0, n);

    // reset in the middle of the right slot of a playing frame, word pending
    load_word(1'b0, 1, 32'h0F0F_0F0F, 32'hFFFF_FFFF, {1'b0, 32'h0F0F_0F0F, 32'hFFFF_FFFF});
    sync_frame(1'b0, n);
    repeat (2) @(posedge sck);
    #1 drive(1'b0, 1'b1, 32'h1111_1111, 32'h2222_2222);
    @(posedge sck);
    #1 drive(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (37) @(posedge sck);
    chk("A_pre_reset_ws", 64'(ws_a), 64'd1);
    chk("A_pre_reset_sd", 64'(sd_a), 64'd1);
    chk("A_pre_reset_ready", 64'(ready_a), 64'd0);
    #1 rst_a_n = 1'b0;
    exp_a_q.delete();
    #1;
    chk("A_midreset_ws", 64'(ws_a), 64'd0);
    chk("A_midreset_sd", 64'(sd_a), 64'd0);
    chk("A_midreset_ready", 64'(ready_a), 64'd1);
    chk("A_midreset_frame_start", 64'(fs_a), 64'd0);
    chk("A_midreset_underrun", 64'(ur_a), 64'd0);
    repeat (2) @(posedge sck);
    #1 rst_a_n = 1'b1;
    push_exp(1'b0, {1'b1, 64'd0});
    sync_frame(1'b0, n);
    chk("A_restart_frame_start_edges", 64'(n), 64'd1);
    load_word(1'b0, 10, 32'hA5A5_A5A5, 32'h5A5A_5A5A, {1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A});
    sync_frame(1'b0, n);
    idle_frame(1'b0);
    sync_frame(1'b0, n);
    drain(1'b0);
    rst_a_n = 1'b0;

    // padded instance: table of 24-bit words in 32-bit slots
    @(posedge sck);
    #1 rst_b_n = 1'b1;
    push_exp(1'b1, {1'b1, 64'd0});
    sync_frame(1'b1, n);
    chk("B_first_frame_start_edges", 64'(n), 64'd1);
    for (int i = 0; i < 5; i++) begin
      load_word(1'b1, int'($urandom_range(0, 62)), tbl[i].l, tbl[i].r,
                {1'b0, tbl[i].exp_l, tbl[i].exp_r});
      sync_frame(1'b1, n);
    end
    idle_frame(1'b1);
    sync_frame(1'b1, n);
    drain(1'b1);
    rst_b_n = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
